// File: rtl/cc_operand_loader_if.sv
// Stream-in / frame-out bundle between the nibble source, the loader and the CC stage.
interface cc_operand_loader_if;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned OPT_W = 3;

  logic             in_valid;
  logic [NIB_W-1:0] in_data;
  logic [OPT_W-1:0] in_opt;
  logic             in_clr;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [OPT_W-1:0] out_opt;
  logic [NIB_W-1:0] out_n0;
  logic [NIB_W-1:0] out_n1;
  logic [NIB_W-1:0] out_n2;
  logic [NIB_W-1:0] out_n3;
  logic [NIB_W-1:0] out_n4;

  // Source + consumer side (drives nibbles, accepts frames)
  modport master (
    output in_valid, in_data, in_opt, in_clr, out_ready,
    input  in_ready, out_valid, out_opt, out_n0, out_n1, out_n2, out_n3, out_n4
  );

  // Loader side
  modport slave (
    input  in_valid, in_data, in_opt, in_clr, out_ready,
    output in_ready, out_valid, out_opt, out_n0, out_n1, out_n2, out_n3, out_n4
  );
endinterface

// File: rtl/cc_operand_loader.sv
// Serial nibble loader: assembles 5-nibble frames into a 2-deep ping-pong buffer
// and presents the oldest committed frame in parallel to the CC stage.
module cc_operand_loader (
  input  logic                 clk,
  input  logic                 rst_n,
  cc_operand_loader_if.slave   bus
);
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned OPT_W   = 3;
  localparam int unsigned FRAME_N = 5;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned DEPTH   = 2;

  typedef struct packed {
    logic [OPT_W-1:0]              opt;
    logic [FRAME_N-1:0][NIB_W-1:0] nib;
  } frame_t;

  frame_t           bank_q [DEPTH];
  frame_t           bank_d [DEPTH];
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  frame_t           out_q, out_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic accept_c;
  logic commit_c;
  logic pop_c;

  assign accept_c = bus.in_valid & in_ready_q;
  assign pop_c    = out_valid_q & bus.out_ready;
  assign commit_c = accept_c & ~bus.in_clr & (idx_q == IDX_W'(FRAME_N - 1));

  // Next-state: nibble write, pointer/count bookkeeping, and the registered view of the read bank
  always_comb begin
    bank_d      = bank_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;

    if (bus.in_clr) begin
      idx_d = '0;
    end else if (accept_c) begin
      bank_d[wr_bank_q].nib[idx_q] = bus.in_data;
      if (idx_q == '0) begin
        bank_d[wr_bank_q].opt = bus.in_opt;
      end
      if (idx_q == IDX_W'(FRAME_N - 1)) begin
        idx_d     = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    if (pop_c) begin
      rd_bank_d = ~rd_bank_q;
    end

    unique case ({commit_c, pop_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    in_ready_d  = (cnt_d != CNT_W'(DEPTH));
    out_valid_d = (cnt_d != '0);
    out_d       = bank_d[rd_bank_d];
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0]   <= '0;
      bank_q[1]   <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_opt   = out_q.opt;
  assign bus.out_n0    = out_q.nib[0];
  assign bus.out_n1    = out_q.nib[1];
  assign bus.out_n2    = out_q.nib[2];
  assign bus.out_n3    = out_q.nib[3];
  assign bus.out_n4    = out_q.nib[4];
endmodule
